// File: rtl/psum_acc_sequencer.sv
// Partial-sum accumulation sequencer.
// Walks every output pixel (onij) of a convolution and, for each, reads the
// len_kij partial sums from PMEM while the SFU accumulates, then flushes,
// waits out the read/ReLU latency and strobes the finished pixel.
module psum_acc_sequencer #(
  parameter int unsigned in_w       = 6,
  parameter int unsigned out_w      = 4,
  parameter int unsigned ksz        = 3,
  parameter int unsigned kij_stride = 36,
  parameter int unsigned base_addr  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        CEN_pmem,
  output logic        WEN_pmem,
  output logic [10:0] A_pmem,
  output logic        acc,
  output logic        out_valid,
  output logic [3:0]  onij_idx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned len_onij = out_w * out_w;
  localparam int unsigned len_kij  = ksz * ksz;
  localparam int unsigned kij_bits = (len_kij > 1) ? $clog2(len_kij) : 1;
  localparam int unsigned pos_bits = (out_w > 1) ? $clog2(out_w) : 1;
  localparam int unsigned k_bits   = (ksz > 1) ? $clog2(ksz) : 1;

  localparam logic [3:0]          last_onij = 4'(len_onij - 1);
  localparam logic [kij_bits-1:0] last_kij  = kij_bits'(len_kij - 1);
  localparam logic [pos_bits-1:0] last_pos  = pos_bits'(out_w - 1);
  localparam logic [k_bits-1:0]   last_k    = k_bits'(ksz - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FLUSH,
    WAIT,
    EMIT,
    DONE
  } state_t;

  state_t              state, state_n;
  logic [3:0]          onij, onij_n;
  logic [pos_bits-1:0] r, r_n, c, c_n;
  logic [kij_bits-1:0] kij, kij_n;
  logic [k_bits-1:0]   ki, ki_n, kj, kj_n;
  logic                wait_cnt, wait_n;

  logic        cen_d, acc_d, ov_d, busy_d, done_d;
  logic [10:0] addr_d;
  logic [3:0]  idx_d;

  // State and position counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      onij     <= '0;
      r        <= '0;
      c        <= '0;
      kij      <= '0;
      ki       <= '0;
      kj       <= '0;
      wait_cnt <= 1'b0;
    end else begin
      state    <= state_n;
      onij     <= onij_n;
      r        <= r_n;
      c        <= c_n;
      kij      <= kij_n;
      ki       <= ki_n;
      kj       <= kj_n;
      wait_cnt <= wait_n;
    end
  end

  // Next-state and counter advance; row/column and ki/kj are kept as
  // separate counters so no divider is needed for non-power-of-two sizes
  always_comb begin
    state_n = state;
    onij_n  = onij;
    r_n     = r;
    c_n     = c;
    kij_n   = kij;
    ki_n    = ki;
    kj_n    = kj;
    wait_n  = wait_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          onij_n  = '0;
          r_n     = '0;
          c_n     = '0;
          kij_n   = '0;
          ki_n    = '0;
          kj_n    = '0;
        end
      end
      READ: begin
        if (kij == last_kij) begin
          state_n = FLUSH;
        end else begin
          kij_n = kij + kij_bits'(1);
          if (kj == last_k) begin
            kj_n = '0;
            ki_n = ki + k_bits'(1);
          end else begin
            kj_n = kj + k_bits'(1);
          end
        end
      end
      FLUSH: begin
        state_n = WAIT;
        wait_n  = 1'b0;
      end
      WAIT: begin
        if (wait_cnt) state_n = EMIT;
        else          wait_n  = 1'b1;
      end
      EMIT: begin
        if (onij == last_onij) begin
          state_n = DONE;
        end else begin
          state_n = READ;
          onij_n  = onij + 4'd1;
          kij_n   = '0;
          ki_n    = '0;
          kj_n    = '0;
          if (c == last_pos) begin
            c_n = '0;
            r_n = r + pos_bits'(1);
          end else begin
            c_n = c + pos_bits'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe rather than lagging it by a cycle
  always_comb begin
    cen_d  = (state_n != READ);
    acc_d  = (state_n == READ);
    ov_d   = (state_n == EMIT);
    busy_d = (state_n == READ) || (state_n == FLUSH) ||
             (state_n == WAIT) || (state_n == EMIT);
    done_d = (state_n == DONE);
    idx_d  = (state_n == EMIT) ? onij_n : onij_idx;
    addr_d = A_pmem;
    if (state_n == READ) begin
      addr_d = 11'(base_addr)
             + 11'(kij_n) * 11'(kij_stride)
             + (11'(r_n) + 11'(ki_n)) * 11'(in_w)
             + 11'(c_n) + 11'(kj_n);
    end
  end

  // Registered instruction-field outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CEN_pmem  <= 1'b1;
      WEN_pmem  <= 1'b1;
      A_pmem    <= '0;
      acc       <= 1'b0;
      out_valid <= 1'b0;
      onij_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      CEN_pmem  <= cen_d;
      WEN_pmem  <= 1'b1;
      A_pmem    <= addr_d;
      acc       <= acc_d;
      out_valid <= ov_d;
      onij_idx  <= idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_psum_acc_sequencer.sv
// Testbench for psum_acc_sequencer: cycle-indexed vector table for the first
// pass, an address/strobe scoreboard running on every pass, plus reset-abort,
// held-start and non-default-parameter sequences.
module tb_psum_acc_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;

  logic        cen, wen, acc, ov, busy, done;
  logic [10:0] addr;
  logic [3:0]  idx;
  logic        cen2, wen2, acc2, ov2, busy2, done2;
  logic [10:0] addr2;
  logic [3:0]  idx2;

  always #5 clk = ~clk;

  psum_acc_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .CEN_pmem(cen), .WEN_pmem(wen), .A_pmem(addr), .acc(acc),
    .out_valid(ov), .onij_idx(idx), .busy(busy), .done(done)
  );

  psum_acc_sequencer #(.in_w(5), .out_w(3), .ksz(3), .kij_stride(25), .base_addr(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .CEN_pmem(cen2), .WEN_pmem(wen2), .A_pmem(addr2), .acc(acc2),
    .out_valid(ov2), .onij_idx(idx2), .busy(busy2), .done(done2)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard
  int addr_q[$];
  int ov_q[$];
  int exp_done = 0;
  int last_ov = 0;
  int last_read = 0;

  task automatic push_pass();
    for (int o = 0; o < 16; o++) begin
      for (int k = 0; k < 9; k++)
        addr_q.push_back(k * 36 + (o / 4 + k / 3) * 6 + (o % 4 + k % 3));
      ov_q.push_back(o);
    end
    exp_done++;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (!cen) begin
        last_read = cyc;
        if (addr_q.size() == 0) chk("unexpected_read", 1, 0);
        else chk("sb_addr", int'(addr), addr_q.pop_front());
        chk("acc_in_read", acc, 1);
      end else begin
        chk("acc_idle", acc, 0);
      end
      if (ov) begin
        if (ov_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          int e;
          e = ov_q.pop_front();
          chk("sb_onij_idx", int'(idx), e);
          if (e != 0) chk("ov_spacing", cyc - last_ov, 13);
          chk("read_to_ov", cyc - last_read, 4);
        end
        last_ov = cyc;
      end
      if (done) begin
        if (exp_done == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_done--;
          chk("done_after_last_ov", cyc - last_ov, 1);
          chk("busy_in_done", busy, 0);
        end
      end
    end
  end

  // Cycle-indexed expectations relative to the first READ cycle (t=0)
  typedef struct {
    int         t;
    bit         chk_addr;
    int         addr;
    bit         cen;
    bit         acc;
    bit         busy;
    bit         ov;
    bit         dn;
    int         idx;
  } vec_t;
  vec_t tbl[12];

  task automatic kick(output int c0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int c0, t_now, n_ov2, last_addr2, last_idx2, n;
    bit seen_done2;

    tbl[0]  = '{0,   1, 0,   0, 1, 1, 0, 0, 0};
    tbl[1]  = '{4,   1, 151, 0, 1, 1, 0, 0, 0};
    tbl[2]  = '{8,   1, 302, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{9,   0, 0,   1, 0, 1, 0, 0, 0};
    tbl[4]  = '{11,  0, 0,   1, 0, 1, 0, 0, 0};
    tbl[5]  = '{12,  0, 0,   1, 0, 1, 1, 0, 0};
    tbl[6]  = '{13,  1, 1,   0, 1, 1, 0, 0, 0};
    tbl[7]  = '{65,  1, 7,   0, 1, 1, 0, 0, 4};
    tbl[8]  = '{203, 1, 323, 0, 1, 1, 0, 0, 14};
    tbl[9]  = '{207, 0, 0,   1, 0, 1, 1, 0, 15};
    tbl[10] = '{208, 0, 0,   1, 0, 0, 0, 1, 15};
    tbl[11] = '{209, 0, 0,   1, 0, 0, 0, 0, 15};

    // Reset values
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cen", cen, 1);
    chk("rst_wen", wen, 1);
    chk("rst_addr", int'(addr), 0);
    chk("rst_acc", acc, 0);
    chk("rst_ov", ov, 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Pass 1: vector table
    push_pass();
    kick(c0);
    @(negedge clk);
    t_now = 0;
    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].t - t_now) @(negedge clk);
      t_now = tbl[i].t;
      if (tbl[i].chk_addr) chk($sformatf("row%0d_addr", i), int'(addr), tbl[i].addr);
      chk($sformatf("row%0d_cen", i), cen, tbl[i].cen);
      chk($sformatf("row%0d_wen", i), wen, 1);
      chk($sformatf("row%0d_acc", i), acc, tbl[i].acc);
      chk($sformatf("row%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("row%0d_ov", i), ov, tbl[i].ov);
      chk($sformatf("row%0d_done", i), done, tbl[i].dn);
      chk($sformatf("row%0d_idx", i), int'(idx), tbl[i].idx);
    end
    chk("pass1_reads_left", addr_q.size(), 0);
    chk("pass1_ov_left", ov_q.size(), 0);

    // Pass 2: start held through the pass and the DONE cycle
    repeat (2) @(negedge clk);
    push_pass();
    start = 1'b1;
    @(negedge clk);
    wait_done("held_start");
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("held_busy_after", busy, 0);
    chk("held_cen_after", cen, 1);
    chk("held_reads_left", addr_q.size(), 0);
    chk("held_done_left", exp_done, 0);

    // Pass 3: reset during READ of onij 7, kij 4
    push_pass();
    kick(c0);
    @(negedge clk);
    repeat (95) @(negedge clk);
    chk("abort_addr_o7k4", int'(addr), 160);
    chk("abort_idx_before", int'(idx), 6);
    #2;
    reset = 1'b0;
    addr_q.delete();
    ov_q.delete();
    exp_done = 0;
    #1;
    chk("abort_cen", cen, 1);
    chk("abort_wen", wen, 1);
    chk("abort_addr", int'(addr), 0);
    chk("abort_acc", acc, 0);
    chk("abort_ov", ov, 0);
    chk("abort_idx", int'(idx), 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_abort_idle", busy, 0);
    push_pass();
    kick(c0);
    @(negedge clk);
    chk("restart_addr", int'(addr), 0);
    chk("restart_cen", cen, 0);
    wait_done("restart");
    @(negedge clk);

    // Non-default parameters
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n_ov2 = 0;
    last_addr2 = -1;
    last_idx2 = -1;
    seen_done2 = 1'b0;
    n = 0;
    while (!seen_done2 && n < 300) begin
      @(negedge clk);
      n++;
      if (!cen2) last_addr2 = int'(addr2);
      if (ov2) begin
        chk("p2_idx_order", int'(idx2), n_ov2);
        n_ov2++;
        last_idx2 = int'(idx2);
      end
      if (done2) seen_done2 = 1'b1;
    end
    chk("p2_done_seen", seen_done2, 1);
    chk("p2_ov_count", n_ov2, 9);
    chk("p2_last_idx", last_idx2, 8);
    chk("p2_last_addr", last_addr2, 224);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
